cipher: RTL and testbench
=========================

Name: cipher

Overview:
- Bit-serial LFSR stream cipher with a built-in loopback decryptor, used as a self-checking encrypt/decrypt block.
- Three maximal-length Fibonacci LFSRs (5, 7 and 9 bits) are seeded from key inputs. Their output bits are XORed into a one-bit keystream.
- Plaintext XOR keystream gives the ciphertext. Ciphertext XOR the same keystream gives the decrypted bit, which always equals plaintext.

Parameters:
- None. Widths (5/7/9) and taps are fixed constants in the package.

Ports:
- clk  input  1  system clock; all state advances on the rising edge.
- reset  input  1  asynchronous, active-low reset. While low, the LFSRs load their seeds.
- key1  input  5  seed for LFSR1.
- key2  input  7  seed for LFSR2.
- key3  input  9  seed for LFSR3.
- plaintext  input  1  message bit for the current cycle.
- keystream  output  1  current keystream bit.
- ciphertext  output  1  plaintext ^ keystream.
- decrypted  output  1  ciphertext ^ keystream.

Behaviour:
- Reset (reset low, asynchronous): LFSR1 = key1, LFSR2 = key2, LFSR3 = key3.
  - Any all-zero key is replaced by 1 (LSB set) so that no LFSR can lock up.
  - Keys are treated as static while reset is asserted.
  - Reset asserted mid-stream reloads the seeds immediately. The sequence restarts from step 0.
- Each LFSR, state s[N-1:0]:
  - output bit o = s[N-1] (MSB).
  - next state = {s[N-2:0], fb}, i.e. shift left with feedback into the LSB.
  - LFSR1 (N=5): fb = s[4]^s[2], polynomial x^5+x^3+1.
  - LFSR2 (N=7): fb = s[6]^s[5], polynomial x^7+x^6+1.
  - LFSR3 (N=9): fb = s[8]^s[4], polynomial x^9+x^5+1.
- Stepping: all three LFSRs advance on every rising clk edge while reset is high. There is no enable.
- Step k denotes the state after k rising edges since reset release; step 0 is the seed state.
- keystream = o1 ^ o2 ^ o3. It is a combinational function of the current LFSR states.
- ciphertext and decrypted are combinational, with zero latency from plaintext.
  - decrypted == plaintext in every cycle, including during reset.
- Outputs during reset: keystream reflects the seed states (no forced value). ciphertext and decrypted follow from it.
- Periods: LFSR1 31, LFSR2 127, LFSR3 511. The combined keystream period is 31*127*511.
- No X may propagate on any output after reset has been asserted once.

Decomposition:
- Package cipher_pkg holds:
  - width constants W1=5, W2=7, W3=9;
  - tap-mask constants 5'b10100, 7'b1100000, 9'b100010000;
  - the zero-seed substitute value 1.
- One sub-module, lfsr, parameterised by WIDTH and TAPS.
  - Ports: clk, reset, seed, state, out_bit; fb is the XOR-reduce of state & TAPS.
  - Instantiated three times.
  - Zero-seed substitution is done inside lfsr.

Test Plan:
- Reset with key1=5'h15, key2=7'h65, key3=9'h14b, then release.
  - Per-LFSR output bits at steps 0..7: o1 = 10101000, o2 = 11001010, o3 = 10100101.
  - keystream at steps 0..7 = 1,1,0,0,0,1,1,1.
- Same seeds, plaintext 8'b10101100 applied MSB first, one bit per step from step 0.
  - ciphertext = 0,1,1,0,1,0,1,1.
  - decrypted = 1,0,1,0,1,1,0,0, matching plaintext on every bit.
- key1 = 0 (key2 and key3 as above).
  - LFSR1 starts at 5'b00001 and its state returns to 00001 after exactly 31 steps.
  - LFSR1 state is never 0.
- Run 100 cycles, assert reset asynchronously between clock edges, then release.
  - LFSR states equal the seeds immediately on reset assertion.
  - The keystream repeats 1,1,0,0,0,1,1,1 after release.
- Random plaintext for 2000 cycles with random non-zero keys.
  - decrypted === plaintext in every cycle.
  - ciphertext === plaintext ^ keystream in every cycle.
  - LFSR2 state period is 127; LFSR3 state period is 511.

Source files
------------

// File: rtl/cipher_pkg.sv
// Shared constants for the three-LFSR stream cipher: register widths,
// feedback tap masks and the substitute seed used when a key is all-zero.
package cipher_pkg;

  localparam int W1 = 5;
  localparam int W2 = 7;
  localparam int W3 = 9;

  // Tap masks select the state bits XORed into the LSB on each shift.
  localparam logic [W1-1:0] TAPS1 = 5'b10100;      // x^5 + x^3 + 1
  localparam logic [W2-1:0] TAPS2 = 7'b1100000;    // x^7 + x^6 + 1
  localparam logic [W3-1:0] TAPS3 = 9'b100010000;  // x^9 + x^5 + 1

  localparam int unsigned ZERO_SEED_SUB = 1;

endpackage : cipher_pkg

// File: rtl/cipher_lfsr.sv
// Fibonacci LFSR: shifts left, feedback into the LSB, output taken from the MSB.
// An all-zero seed is swapped for a non-zero value so the register never locks up.
module lfsr
  import cipher_pkg::*;
#(
  parameter int              WIDTH = 5,
  parameter logic [WIDTH-1:0] TAPS  = 5'b10100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] state,
  output logic             out_bit
);

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] w_seed;
  logic             w_fb;

  assign w_seed = (seed == '0) ? WIDTH'(ZERO_SEED_SUB) : seed;
  assign w_fb   = ^(r_state & TAPS);

  // Seed is reloaded asynchronously; keys are static while reset is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= w_seed;
    else        r_state <= {r_state[WIDTH-2:0], w_fb};
  end

  assign state   = r_state;
  assign out_bit = r_state[WIDTH-1];

endmodule : lfsr

// File: rtl/cipher.sv
// Bit-serial stream cipher: three LFSR output bits XOR into a keystream that
// encrypts the plaintext, and the same keystream decrypts it again in loopback.
module cipher
  import cipher_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [W1-1:0] key1,
  input  logic [W2-1:0] key2,
  input  logic [W3-1:0] key3,
  input  logic          plaintext,
  output logic          keystream,
  output logic          ciphertext,
  output logic          decrypted
);

  logic [W1-1:0] w_s1;
  logic [W2-1:0] w_s2;
  logic [W3-1:0] w_s3;
  logic          w_o1, w_o2, w_o3;
  logic          w_ks;
  logic          w_ct;

  lfsr #(.WIDTH(W1), .TAPS(TAPS1)) u_lfsr1 (
    .clk     (clk),
    .reset   (reset),
    .seed    (key1),
    .state   (w_s1),
    .out_bit (w_o1)
  );

  lfsr #(.WIDTH(W2), .TAPS(TAPS2)) u_lfsr2 (
    .clk     (clk),
    .reset   (reset),
    .seed    (key2),
    .state   (w_s2),
    .out_bit (w_o2)
  );

  lfsr #(.WIDTH(W3), .TAPS(TAPS3)) u_lfsr3 (
    .clk     (clk),
    .reset   (reset),
    .seed    (key3),
    .state   (w_s3),
    .out_bit (w_o3)
  );

  // Everything downstream of the LFSR states is combinational, zero latency.
  assign w_ks       = w_o1 ^ w_o2 ^ w_o3;
  assign w_ct       = plaintext ^ w_ks;
  assign keystream  = w_ks;
  assign ciphertext = w_ct;
  assign decrypted  = w_ct ^ w_ks;

endmodule : cipher

// File: tb/tb_cipher.sv
// Self-checking bench for cipher: reference model steps each LFSR from its
// characteristic polynomial and predicts keystream/ciphertext every cycle.
module tb_cipher;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] key1;
  logic [6:0] key2;
  logic [8:0] key3;
  logic       plaintext;
  logic       keystream, ciphertext, decrypted;

  int checks = 0;
  int errors = 0;

  cipher dut (
    .clk        (clk),
    .reset      (reset),
    .key1       (key1),
    .key2       (key2),
    .key3       (key3),
    .plaintext  (plaintext),
    .keystream  (keystream),
    .ciphertext (ciphertext),
    .decrypted  (decrypted)
  );

  always #5 clk = ~clk;

  // Reference model: polynomial x^n + x^m + 1, shift left, feedback into LSB.
  logic [8:0] m_s [3];
  int         m_n [3] = '{5, 7, 9};
  int         m_m [3] = '{3, 6, 5};

  function automatic logic [8:0] poly_step(input logic [8:0] s, input int n, input int m);
    logic fb;
    logic [8:0] mask;
    fb   = s[n-1] ^ s[m-1];
    mask = (9'd1 << n) - 9'd1;
    return ((s << 1) | {8'd0, fb}) & mask;
  endfunction

  function automatic logic m_ks();
    logic k;
    k = 1'b0;
    for (int i = 0; i < 3; i++) k ^= m_s[i][m_n[i]-1];
    return k;
  endfunction

  task automatic m_seed();
    m_s[0] = (key1 == 0) ? 9'd1 : {4'd0, key1};
    m_s[1] = (key2 == 0) ? 9'd1 : {2'd0, key2};
    m_s[2] = (key3 == 0) ? 9'd1 : key3;
  endtask

  // Advance one clock: wait for the rising edge, settle, step the model.
  task automatic advance();
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) m_s[i] = poly_step(m_s[i], m_n[i], m_m[i]);
  endtask

  // Pulse reset mid-cycle with the given keys; leaves the DUT at step 0.
  task automatic do_reset(input logic [4:0] k1, input logic [6:0] k2, input logic [8:0] k3);
    @(posedge clk);
    #2;
    key1 = k1; key2 = k2; key3 = k3;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    m_seed();
  endtask

  task automatic test_reset();
    @(posedge clk);
    #2;
    key1 = 5'h15; key2 = 7'h65; key3 = 9'h14b;
    plaintext = 1'b0;
    reset = 1'b0;
    m_seed();
    #1;
    checks++;
    if (dut.u_lfsr1.state !== 5'h15 || dut.u_lfsr2.state !== 7'h65 || dut.u_lfsr3.state !== 9'h14b) begin
      errors++;
      $display("FAIL reset_seed: got %h %h %h want 15 65 14b",
               dut.u_lfsr1.state, dut.u_lfsr2.state, dut.u_lfsr3.state);
    end
    checks++;
    if (keystream !== 1'b1) begin
      errors++; $display("FAIL reset_keystream: got %b want 1", keystream);
    end
    for (int p = 0; p < 2; p++) begin
      plaintext = p[0];
      #1;
      checks++;
      if (decrypted !== plaintext || ciphertext !== (plaintext ^ 1'b1)) begin
        errors++;
        $display("FAIL reset_datapath: pt=%b ct=%b dec=%b want ct=%b dec=%b",
                 plaintext, ciphertext, decrypted, plaintext ^ 1'b1, plaintext);
      end
    end
    // Clock edges while reset is held must not move the state.
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (dut.u_lfsr1.state !== 5'h15 || dut.u_lfsr2.state !== 7'h65 || dut.u_lfsr3.state !== 9'h14b) begin
      errors++;
      $display("FAIL reset_hold: got %h %h %h want 15 65 14b",
               dut.u_lfsr1.state, dut.u_lfsr2.state, dut.u_lfsr3.state);
    end
    reset = 1'b1;
  endtask

  task automatic test_vectors();
    logic [7:0] e1, e2, e3, eks;
    e1 = 8'b10101000; e2 = 8'b11001010; e3 = 8'b10100101; eks = 8'b11000111;
    do_reset(5'h15, 7'h65, 9'h14b);
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (dut.u_lfsr1.out_bit !== e1[7-k] || dut.u_lfsr2.out_bit !== e2[7-k] ||
          dut.u_lfsr3.out_bit !== e3[7-k]) begin
        errors++;
        $display("FAIL vec_outbits step %0d: got %b%b%b want %b%b%b", k,
                 dut.u_lfsr1.out_bit, dut.u_lfsr2.out_bit, dut.u_lfsr3.out_bit,
                 e1[7-k], e2[7-k], e3[7-k]);
      end
      checks++;
      if (keystream !== eks[7-k] || keystream !== m_ks()) begin
        errors++;
        $display("FAIL vec_keystream step %0d: got %b want %b (model %b)", k, keystream, eks[7-k], m_ks());
      end
      advance();
    end
  endtask

  task automatic test_plaintext();
    logic [7:0] pt, ect;
    pt = 8'b10101100; ect = 8'b01101011;
    do_reset(5'h15, 7'h65, 9'h14b);
    for (int k = 0; k < 8; k++) begin
      plaintext = pt[7-k];
      #1;
      checks++;
      if (ciphertext !== ect[7-k] || decrypted !== pt[7-k]) begin
        errors++;
        $display("FAIL pt_vector step %0d: ct=%b dec=%b want ct=%b dec=%b",
                 k, ciphertext, decrypted, ect[7-k], pt[7-k]);
      end
      advance();
    end
  endtask

  task automatic test_zero_key();
    int first_ret;
    bit saw_zero;
    first_ret = 0; saw_zero = 0;
    do_reset(5'h00, 7'h65, 9'h14b);
    #1;
    checks++;
    if (dut.u_lfsr1.state !== 5'b00001) begin
      errors++; $display("FAIL zero_key_seed: got %b want 00001", dut.u_lfsr1.state);
    end
    for (int k = 1; k <= 31; k++) begin
      advance();
      if (dut.u_lfsr1.state === 5'd0) saw_zero = 1;
      if (dut.u_lfsr1.state === 5'b00001 && first_ret == 0) first_ret = k;
    end
    checks++;
    if (first_ret != 31) begin
      errors++; $display("FAIL zero_key_period: got %0d want 31", first_ret);
    end
    checks++;
    if (saw_zero) begin
      errors++; $display("FAIL zero_key_lockup: got state 0 want nonzero");
    end
  endtask

  task automatic test_midstream_reset();
    logic [7:0] eks;
    int bad;
    eks = 8'b11000111;
    bad = 0;
    do_reset(5'h15, 7'h65, 9'h14b);
    for (int k = 0; k < 100; k++) begin
      #1;
      if (keystream !== m_ks()) bad++;
      advance();
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL mid_run_keystream: got %0d bad cycles want 0", bad);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (dut.u_lfsr1.state !== 5'h15 || dut.u_lfsr2.state !== 7'h65 || dut.u_lfsr3.state !== 9'h14b) begin
      errors++;
      $display("FAIL mid_async_reload: got %h %h %h want 15 65 14b",
               dut.u_lfsr1.state, dut.u_lfsr2.state, dut.u_lfsr3.state);
    end
    #1;
    reset = 1'b1;
    m_seed();
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (keystream !== eks[7-k]) begin
        errors++; $display("FAIL mid_restart step %0d: got %b want %b", k, keystream, eks[7-k]);
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic [6:0] s2;
    logic [8:0] s3;
    int p2, p3, bad_dec, bad_ct, bad_ks;
    p2 = 0; p3 = 0; bad_dec = 0; bad_ct = 0; bad_ks = 0;
    s2 = 7'($urandom_range(1, 127));
    s3 = 9'($urandom_range(1, 511));
    do_reset(5'($urandom_range(1, 31)), s2, s3);
    for (int k = 0; k < 2000; k++) begin
      plaintext = 1'($urandom);
      #1;
      if (decrypted !== plaintext) bad_dec++;
      if (ciphertext !== (plaintext ^ m_ks())) bad_ct++;
      if (keystream !== m_ks()) bad_ks++;
      if (k > 0 && p2 == 0 && dut.u_lfsr2.state === s2) p2 = k;
      if (k > 0 && p3 == 0 && dut.u_lfsr3.state === s3) p3 = k;
      advance();
    end
    checks++;
    if (bad_dec != 0) begin
      errors++; $display("FAIL rand_decrypted: got %0d bad cycles want 0", bad_dec);
    end
    checks++;
    if (bad_ct != 0) begin
      errors++; $display("FAIL rand_ciphertext: got %0d bad cycles want 0", bad_ct);
    end
    checks++;
    if (bad_ks != 0) begin
      errors++; $display("FAIL rand_keystream: got %0d bad cycles want 0", bad_ks);
    end
    checks++;
    if (p2 != 127) begin
      errors++; $display("FAIL rand_period2: got %0d want 127", p2);
    end
    checks++;
    if (p3 != 511) begin
      errors++; $display("FAIL rand_period3: got %0d want 511", p3);
    end
  endtask

  initial begin
    reset = 1'b1;
    plaintext = 1'b0;
    key1 = 5'h15; key2 = 7'h65; key3 = 9'h14b;
    test_reset();
    test_vectors();
    test_plaintext();
    test_zero_key();
    test_midstream_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_cipher
